// File: rtl/hid_key_injector_if.sv
// Signal bundle between the MCU byte receiver / key-queue producer and the hid byte input.
// The master side drives MCU bytes and key pushes; the slave side is the injector.
interface hid_key_injector_if #(
  parameter int FIFO_DEPTH = 8
);
  logic                          mcu_strobe;
  logic                          mcu_start;
  logic [7:0]                    mcu_data;
  logic                          inj_valid;
  logic [6:0]                    inj_code;
  logic                          inj_ready;
  logic                          hid_strobe;
  logic                          hid_start;
  logic [7:0]                    hid_data;
  logic                          inj_busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  modport master (
    output mcu_strobe, mcu_start, mcu_data, inj_valid, inj_code,
    input  inj_ready, hid_strobe, hid_start, hid_data, inj_busy, fifo_level
  );

  modport slave (
    input  mcu_strobe, mcu_start, mcu_data, inj_valid, inj_code,
    output inj_ready, hid_strobe, hid_start, hid_data, inj_busy, fifo_level
  );
endinterface

// File: rtl/hid_key_injector.sv
// Merges the unstallable MCU byte stream with locally queued key presses, emitting each key
// as a CMD 1 press packet, a hold time, a release packet and a gap, never splitting MCU packets.
module hid_key_injector #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] HOLD_CYCLES = 16'd50000,
  parameter logic [15:0] GAP_CYCLES  = 16'd50000,
  parameter logic [7:0]  IDLE_GAP    = 8'd64
) (
  input  logic              clk,
  input  logic              reset_n,
  hid_key_injector_if.slave bus
);
  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam int            LW         = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [7:0]    KBD_CMD    = 8'h01;

  typedef enum logic [2:0] {
    IDLE, PRESS_CMD, PRESS_CODE, HOLD, REL_WAIT, REL_CMD, REL_CODE, GAP
  } state_t;

  state_t        state;
  logic [15:0]   wait_cnt;
  logic [6:0]    code;
  logic [6:0]    q_mem [FIFO_DEPTH];
  logic [AW-1:0] q_rd;
  logic [AW-1:0] q_wr;
  logic [LW-1:0] q_level;
  logic [LW-1:0] level_next;
  logic          ready;
  logic [8:0]    skid_mem [2];
  logic          skid_rd;
  logic          skid_wr;
  logic [1:0]    skid_cnt;
  logic          mcu_active;
  logic [7:0]    idle_cnt;
  logic          out_strobe;
  logic          out_start;
  logic [7:0]    out_data;
  logic          busy;
  logic          start_ok;
  logic          launch;
  logic          rel_go;
  logic          inj_first;
  logic          inj_emit;
  logic          push;
  logic          skid_push;
  logic          skid_pop;
  logic          idle_next;
  logic [7:0]    inj_byte;

  // Per-cycle arbitration: who owns the hid output and what every queue does this edge.
  always_comb begin
    start_ok   = !mcu_active && !bus.mcu_strobe && (skid_cnt == 2'd0);
    launch     = (state == IDLE) && (q_level != {LW{1'b0}}) && start_ok;
    rel_go     = (state == REL_WAIT) && start_ok;
    inj_first  = launch || rel_go;
    // The CMD/CODE burst is atomic: the CODE byte goes out unconditionally.
    inj_emit   = inj_first || (state == PRESS_CMD) || (state == REL_CMD);
    push       = bus.inj_valid && ready;
    skid_pop   = !inj_emit && (skid_cnt != 2'd0);
    skid_push  = bus.mcu_strobe && (inj_emit || (skid_cnt != 2'd0)) &&
                 ((skid_cnt != 2'd2) || skid_pop);
    level_next = q_level + LW'(push) - LW'(launch);
    idle_next  = ((state == IDLE) && !launch) || ((state == GAP) && (wait_cnt == 16'd0));
    case (state)
      PRESS_CMD: inj_byte = {1'b0, code};
      REL_CMD:   inj_byte = {1'b1, code};
      default:   inj_byte = KBD_CMD;
    endcase
  end

  // Key queue: popped when a press packet launches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_rd    <= {AW{1'b0}};
      q_wr    <= {AW{1'b0}};
      q_level <= {LW{1'b0}};
      ready   <= 1'b1;
    end else begin
      if (push) begin
        q_mem[q_wr] <= bus.inj_code;
        q_wr        <= q_wr + AW'(1);
      end
      if (launch) begin
        q_rd <= q_rd + AW'(1);
      end
      q_level <= level_next;
      ready   <= (level_next != FULL_LEVEL);
    end
  end

  // Skid FIFO holding MCU bytes that collide with injector output or earlier skid bytes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      skid_rd  <= 1'b0;
      skid_wr  <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (skid_push) begin
        skid_mem[skid_wr] <= {bus.mcu_start, bus.mcu_data};
        skid_wr           <= !skid_wr;
      end
      if (skid_pop) begin
        skid_rd <= !skid_rd;
      end
      skid_cnt <= skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};
    end
  end

  // MCU packet tracking: a packet is open from its start byte until IDLE_GAP silent clocks.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcu_active <= 1'b0;
      idle_cnt   <= 8'd0;
    end else if (bus.mcu_strobe) begin
      idle_cnt <= IDLE_GAP;
      if (bus.mcu_start) begin
        mcu_active <= 1'b1;
      end
    end else if (idle_cnt > 8'd1) begin
      idle_cnt <= idle_cnt - 8'd1;
    end else begin
      idle_cnt   <= 8'd0;
      mcu_active <= 1'b0;
    end
  end

  // Key sequencer: press burst, hold, release burst, gap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= 16'd0;
      code     <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state <= PRESS_CMD;
            code  <= q_mem[q_rd];
          end
        end
        PRESS_CMD:  state <= PRESS_CODE;
        PRESS_CODE: begin
          state    <= HOLD;
          wait_cnt <= HOLD_CYCLES;
        end
        HOLD: begin
          if (wait_cnt == 16'd0) begin
            state <= REL_WAIT;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end
        REL_WAIT: begin
          if (rel_go) begin
            state <= REL_CMD;
          end
        end
        REL_CMD:  state <= REL_CODE;
        REL_CODE: begin
          state    <= GAP;
          wait_cnt <= GAP_CYCLES;
        end
        GAP: begin
          if (wait_cnt == 16'd0) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: injector first, then skid backlog, then live MCU byte.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_strobe <= 1'b0;
      out_start  <= 1'b0;
      out_data   <= 8'h00;
      busy       <= 1'b0;
    end else begin
      if (inj_emit) begin
        out_strobe <= 1'b1;
        out_start  <= inj_first;
        out_data   <= inj_byte;
      end else if (skid_cnt != 2'd0) begin
        out_strobe            <= 1'b1;
        {out_start, out_data} <= skid_mem[skid_rd];
      end else if (bus.mcu_strobe) begin
        out_strobe <= 1'b1;
        out_start  <= bus.mcu_start;
        out_data   <= bus.mcu_data;
      end else begin
        out_strobe <= 1'b0;
        out_start  <= 1'b0;
      end
      busy <= !idle_next || (level_next != {LW{1'b0}});
    end
  end

  assign bus.inj_ready  = ready;
  assign bus.hid_strobe = out_strobe;
  assign bus.hid_start  = out_start;
  assign bus.hid_data   = out_data;
  assign bus.inj_busy   = busy;
  assign bus.fifo_level = q_level;

endmodule

// File: tb/tb_hid_key_injector.sv
// Self-checking bench: per-cycle comparison against an event-timeline reference model,
// a vector table for the collision case, directed sequences and a randomized soak.
module tb_hid_key_injector;
  localparam int FD = 8;
  localparam int H  = 20;
  localparam int G  = 10;
  localparam int IG = 12;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hid_key_injector_if #(.FIFO_DEPTH(FD)) bus ();

  hid_key_injector #(
    .FIFO_DEPTH(FD), .HOLD_CYCLES(16'(H)), .GAP_CYCLES(16'(G)), .IDLE_GAP(8'(IG))
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: queues plus absolute edge times at which the next release/press may go.
  logic [6:0] m_q[$];
  logic [8:0] m_skid[$];
  logic [8:0] m_burst[$];
  bit         m_active;
  bit         m_holding;
  logic [6:0] m_code;
  int         m_last, m_rel_at, m_free_at, m_idle_at;
  bit         e_strobe, e_start, e_ready, e_busy;
  logic [7:0] e_data;
  int         e_level;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit         s, ok, emit, full;
    logic [8:0] ob;
    cyc++;
    s = bus.mcu_strobe;
    if (!reset_n) begin
      m_q.delete(); m_skid.delete(); m_burst.delete();
      m_active = 0; m_holding = 0; m_rel_at = 0; m_free_at = 0; m_idle_at = 0;
      e_strobe = 0; e_start = 0; e_data = 8'h00; e_ready = 1; e_busy = 0; e_level = 0;
      return;
    end
    ok   = !m_active && !s && (m_skid.size() == 0);
    full = (m_q.size() >= FD);
    emit = 1;
    ob   = 9'h000;
    if (m_burst.size() != 0) begin
      ob = m_burst.pop_front();
    end else if (!m_holding && cyc >= m_free_at && m_q.size() != 0 && ok) begin
      m_code = m_q.pop_front();
      ob = 9'h101;
      m_burst.push_back({2'b00, m_code});
      m_holding = 1;
      m_rel_at  = cyc + H + 4;
    end else if (m_holding && cyc >= m_rel_at && ok) begin
      ob = 9'h101;
      m_burst.push_back({2'b01, m_code});
      m_holding = 0;
      m_idle_at = cyc + 1 + G + 2;
      m_free_at = cyc + 1 + G + 3;
    end else begin
      emit = 0;
    end
    if (bus.inj_valid && !full) m_q.push_back(bus.inj_code);
    if (emit) begin
      {e_start, e_data} = ob; e_strobe = 1;
      if (s) m_skid.push_back({bus.mcu_start, bus.mcu_data});
    end else if (m_skid.size() != 0) begin
      ob = m_skid.pop_front(); {e_start, e_data} = ob; e_strobe = 1;
      if (s) m_skid.push_back({bus.mcu_start, bus.mcu_data});
    end else if (s) begin
      e_strobe = 1; e_start = bus.mcu_start; e_data = bus.mcu_data;
    end else begin
      e_strobe = 0; e_start = 0;
    end
    if (s) begin
      m_last = cyc;
      if (bus.mcu_start) m_active = 1;
    end else if (m_active && (cyc - m_last >= IG)) begin
      m_active = 0;
    end
    e_level = m_q.size();
    e_ready = (m_q.size() < FD);
    e_busy  = (m_q.size() != 0) || m_holding || (m_burst.size() != 0) || (cyc < m_idle_at);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("m_hid_strobe", int'(bus.hid_strobe), int'(e_strobe));
    chk("m_hid_start", int'(bus.hid_start), int'(e_start));
    chk("m_hid_data", int'(bus.hid_data), int'(e_data));
    chk("m_fifo_level", int'(bus.fifo_level), e_level);
    chk("m_inj_ready", int'(bus.inj_ready), int'(e_ready));
    chk("m_inj_busy", int'(bus.inj_busy), int'(e_busy));
  endtask

  task automatic idle_inputs();
    bus.mcu_strobe = 0; bus.mcu_start = 0; bus.mcu_data = 8'h00;
    bus.inj_valid = 0; bus.inj_code = 7'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic mcu_byte(input bit st, input logic [7:0] d);
    bus.mcu_strobe = 1; bus.mcu_start = st; bus.mcu_data = d;
    tick();
    bus.mcu_strobe = 0; bus.mcu_start = 0;
  endtask

  typedef struct {
    logic       rst_n, ms, mst;
    logic [7:0] md;
    logic       iv;
    logic [6:0] ic;
    logic       es, est;
    logic [7:0] ed;
    int         elvl;
    logic       erdy, ebusy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, fall, cnt, since, pkt_left, quiet;
    int t[4];
    logic [8:0] b[4];
    logic [8:0] got[$];

    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7'h05, 1'b0, 1'b0, 8'h00, 1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 1'b1, 8'h01, 0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 7'h00, 1'b1, 1'b0, 8'h05, 0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 1'b1, 8'h01, 0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0, 8'h01, 0, 1'b1, 1'b1};

    idle_inputs();
    reset_n = 0;
    // Vector table: reset, a push, and an MCU byte colliding with the press burst.
    for (int i = 0; i < 7; i++) begin
      reset_n = vecs[i].rst_n;
      bus.mcu_strobe = vecs[i].ms; bus.mcu_start = vecs[i].mst; bus.mcu_data = vecs[i].md;
      bus.inj_valid = vecs[i].iv; bus.inj_code = vecs[i].ic;
      tick();
      chk("v_strobe", int'(bus.hid_strobe), int'(vecs[i].es));
      chk("v_start", int'(bus.hid_start), int'(vecs[i].est));
      chk("v_data", int'(bus.hid_data), int'(vecs[i].ed));
      chk("v_level", int'(bus.fifo_level), vecs[i].elvl);
      chk("v_ready", int'(bus.inj_ready), int'(vecs[i].erdy));
      chk("v_busy", int'(bus.inj_busy), int'(vecs[i].ebusy));
    end

    // Single key, no MCU traffic: timing of press, release and busy fall.
    do_reset();
    bus.inj_valid = 1; bus.inj_code = 7'h0A;
    tick();
    bus.inj_valid = 0;
    chk("t1_level_push", int'(bus.fifo_level), 1);
    n = 0; fall = -1;
    for (int k = 0; k < 4; k++) begin t[k] = -1; b[k] = 9'h000; end
    for (int j = 1; j <= 200 && fall < 0; j++) begin
      tick();
      if (bus.hid_strobe && n < 4) begin
        t[n] = j; b[n] = {bus.hid_start, bus.hid_data}; n++;
        if (n == 1) chk("t1_level_pop", int'(bus.fifo_level), 0);
      end else if (n == 4 && !bus.inj_busy) begin
        fall = j;
      end
    end
    chk("t1_bytes", n, 4);
    chk("t1_b0", int'(b[0]), 'h101);
    chk("t1_b1", int'(b[1]), 'h00A);
    chk("t1_b2", int'(b[2]), 'h101);
    chk("t1_b3", int'(b[3]), 'h08A);
    chk("t1_press_at", t[0], 1);
    chk("t1_code_at", t[1], 2);
    chk("t1_release_at", t[2], 1 + H + 4);
    chk("t1_relcode_at", t[3], 2 + H + 4);
    chk("t1_busy_fall", fall, 2 + H + 4 + G + 2);

    // MCU packet with a queued key: pass-through, then press only after IG silent clocks.
    do_reset();
    bus.inj_valid = 1; bus.inj_code = 7'h05;
    mcu_byte(1'b1, 8'h03);
    bus.inj_valid = 0;
    chk("t2_b0", int'({bus.hid_strobe, bus.hid_start, bus.hid_data}), 'h303);
    repeat (3) tick();
    mcu_byte(1'b0, 8'h00);
    chk("t2_b1", int'({bus.hid_strobe, bus.hid_start, bus.hid_data}), 'h200);
    repeat (3) tick();
    mcu_byte(1'b0, 8'h21);
    chk("t2_b2", int'({bus.hid_strobe, bus.hid_start, bus.hid_data}), 'h221);
    n = -1;
    for (int j = 1; j <= 100 && n < 0; j++) begin
      tick();
      if (bus.hid_strobe) begin
        n = j;
        chk("t2_press_byte", int'({bus.hid_start, bus.hid_data}), 'h101);
      end
    end
    chk("t2_press_delay", n, IG + 1);

    // Nine pushes into an 8-entry queue while MCU holds the output off.
    do_reset();
    mcu_byte(1'b1, 8'h03);
    for (int i = 0; i < 9; i++) begin
      bus.inj_valid = 1; bus.inj_code = 7'(8'h10 + i);
      tick();
      chk("t4_ready", int'(bus.inj_ready), (i < 7) ? 1 : 0);
      chk("t4_level", int'(bus.fifo_level), (i < 8) ? i + 1 : 8);
    end
    bus.inj_valid = 0;
    got.delete();
    for (int j = 0; j < 600 && got.size() < 32; j++) begin
      tick();
      if (bus.hid_strobe) got.push_back({bus.hid_start, bus.hid_data});
    end
    chk("t4_count", got.size(), 32);
    for (int p = 0; p < got.size(); p++) begin
      case (p % 4)
        1:       chk("t4_press_code", int'(got[p]), 'h010 + p / 4);
        3:       chk("t4_rel_code", int'(got[p]), 'h090 + p / 4);
        default: chk("t4_cmd", int'(got[p]), 'h101);
      endcase
    end
    cnt = 0;
    repeat (60) begin tick(); if (bus.hid_strobe) cnt++; end
    chk("t4_no_ninth", cnt, 0);
    chk("t4_idle", int'(bus.inj_busy), 0);

    // Reset during HOLD: no release afterwards.
    do_reset();
    bus.inj_valid = 1; bus.inj_code = 7'h33;
    tick();
    bus.inj_valid = 0;
    n = -1;
    for (int j = 0; j < 20 && n < 0; j++) begin
      tick();
      if (bus.hid_strobe && !bus.hid_start) n = j;
    end
    chk("t5_press_seen", (n >= 0) ? 1 : 0, 1);
    repeat (5) tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("t5_strobe", int'(bus.hid_strobe), 0);
    chk("t5_level", int'(bus.fifo_level), 0);
    chk("t5_ready", int'(bus.inj_ready), 1);
    chk("t5_busy", int'(bus.inj_busy), 0);
    cnt = 0;
    repeat (H + G + 20) begin tick(); if (bus.hid_strobe) cnt++; end
    chk("t5_no_release", cnt, 0);

    // Push coinciding with the launch pop at level 3.
    do_reset();
    mcu_byte(1'b1, 8'h03);
    for (int i = 0; i < 3; i++) begin
      bus.inj_valid = 1; bus.inj_code = 7'(8'h40 + i);
      tick();
    end
    bus.inj_valid = 0;
    repeat (IG - 3) tick();
    bus.inj_valid = 1; bus.inj_code = 7'h43;
    tick();
    bus.inj_valid = 0;
    chk("t6_level", int'(bus.fifo_level), 3);
    chk("t6_launch", int'({bus.hid_strobe, bus.hid_start, bus.hid_data}), 'h301);

    // Randomized soak against the model.
    do_reset();
    since = 3; pkt_left = 0; quiet = 0;
    for (int j = 0; j < 4000; j++) begin
      idle_inputs();
      reset_n = ($urandom_range(0, 999) != 0);
      since++;
      if (quiet > 0) begin
        quiet--;
      end else if (since >= 3 && $urandom_range(0, 2) == 0) begin
        bus.mcu_strobe = 1;
        bus.mcu_start  = (pkt_left == 0);
        bus.mcu_data   = 8'($urandom);
        if (pkt_left == 0) pkt_left = $urandom_range(1, 4);
        pkt_left--;
        since = 0;
        if (pkt_left == 0 && $urandom_range(0, 1) == 0) quiet = $urandom_range(20, 90);
      end
      bus.inj_valid = ($urandom_range(0, 7) == 0);
      bus.inj_code  = 7'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hid_key_injector.md
Name: hid_key_injector

Overview:
- Arbitrates the hid byte-stream input (strobe/start/data) between two sources:
  - the MCU link (SPI byte receiver), which cannot be stalled;
  - a local key-injection queue used for auto-typing (e.g. LOAD/RUN macros).
- Injected keys are emitted as complete CMD 1 keyboard packets: a press packet, a programmable hold time, then a release packet.
- Injected packets are never interleaved inside an MCU packet.
- Sits between the MCU byte receiver and hid.

Parameters:
- FIFO_DEPTH, 8: injector queue entries (power of two).
- HOLD_CYCLES, 16'd50000: clocks between the press packet and the release packet.
- GAP_CYCLES, 16'd50000: clocks after the release packet before the next key may start.
- IDLE_GAP, 8'd64: clocks without an MCU strobe after which an MCU packet is considered finished.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- mcu_strobe  in  1  MCU byte valid, one-cycle pulse; consecutive pulses ≥3 clocks apart
- mcu_start  in  1  qualifies mcu_strobe: first byte of an MCU packet
- mcu_data  in  8  MCU byte
- inj_valid  in  1  push request into the injector queue
- inj_code  in  7  keymap code to inject
- inj_ready  out  1  queue not full; a push happens when inj_valid && inj_ready
- hid_strobe  out  1  to hid data_in_strobe
- hid_start  out  1  to hid data_in_start
- hid_data  out  8  to hid data_in
- inj_busy  out  1  injector FSM not IDLE, or queue not empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queue occupancy

Behaviour:
- Reset (reset_n=0 sampled at clk edge):
  - hid_strobe=0, hid_start=0, hid_data=8'h00, inj_busy=0, fifo_level=0, inj_ready=1.
  - FSM goes to IDLE; queue, skid buffer and all counters are cleared.
  - A reset issued between press and release does not send a release; hid is reset by the same reset.
- Outputs are registered.
- MCU pass-through:
  - An MCU byte appears on hid_* exactly 1 clock after mcu_strobe, with start and data unchanged, unless the injector owns the output on that cycle.
  - MCU bytes are never dropped.
  - A byte arriving while the injector drives the output goes into a 2-entry skid FIFO and is emitted in order on the following free cycles, one per clock.
  - Skid bytes take priority over any new injector start.
- MCU activity tracking:
  - mcu_active is set on mcu_strobe&&mcu_start.
  - An idle counter reloads on every mcu_strobe; mcu_active clears after IDLE_GAP clocks with no strobe.
  - Injector may start a packet only when: mcu_active=0, mcu_strobe=0 that cycle, and skid FIFO empty.
- Injector queue:
  - Synchronous FIFO of 7-bit codes; push when inj_valid&&inj_ready.
  - Pop at the PRESS_CMD launch.
  - Push and pop in the same cycle keep the level unchanged.
  - A push when full is ignored.
- FSM states and transitions:
  - IDLE → PRESS_CMD when the queue is non-empty and the start condition is true; latch the code.
  - PRESS_CMD: drive strobe=1, start=1, data=8'h01 (one cycle) → PRESS_CODE.
  - PRESS_CODE: drive strobe=1, start=0, data={1'b0,code} (0 = pressed) → HOLD, load counter with HOLD_CYCLES.
  - HOLD: decrement the counter; at 0 → REL_WAIT.
  - REL_WAIT: wait for the start condition → REL_CMD.
  - REL_CMD: strobe=1, start=1, data=8'h01 → REL_CODE.
  - REL_CODE: strobe=1, start=0, data={1'b1,code} → GAP, load counter with GAP_CYCLES.
  - GAP: decrement the counter; at 0 → IDLE.
- The two-cycle CMD/CODE burst is atomic: once started it completes even if MCU bytes arrive, and those bytes are skid-buffered.
- MCU traffic during HOLD or GAP passes straight through; the counters keep running.
- hid_strobe is 0 on every cycle with no source byte; hid_data holds its last value.
- Counter widths are 16 bits; HOLD_CYCLES=0 or GAP_CYCLES=0 means a single-cycle state.

Test Plan:
- Reset, then push code 7'h0A and no MCU traffic:
  - hid sees (start,0x01), then (0x0A) on consecutive clocks.
  - HOLD_CYCLES later: (start,0x01), then (0x8A).
  - fifo_level goes 1→0 and inj_busy falls after GAP.
- MCU packet 0x03,0x00,0x21 with bytes 4 clocks apart, while code 0x05 is queued:
  - hid output equals the MCU bytes, each delayed 1 clock.
  - The injector press starts only after IDLE_GAP clocks of silence.
- mcu_strobe arrives on the PRESS_CMD cycle with data 0x01/start:
  - hid sequence is 0x01(start), 0x05, 0x01(start, MCU byte from skid).
  - No MCU byte is lost.
- Push 9 codes back-to-back with FIFO_DEPTH=8:
  - inj_ready drops after 8 pushes and the 9th push is ignored.
  - The 8 codes are emitted in order.
- Assert reset_n=0 during HOLD:
  - Next clock: hid_strobe=0, fifo_level=0, FSM IDLE, inj_ready=1.
  - No release packet is sent.
- Simultaneous push and pop at fifo_level=3: fifo_level stays 3.
